// File: rtl/fetch_unit.sv
// fetch_unit: WISC-16 fetch stage. Holds the PC, runs a req/done handshake to instruction memory.
// Optional misaligned-fetch trap is compiled in when FETCH_ALIGN_CHK_EN is defined.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Redirect,
  input  logic [15:0] RedirectPC,
  input  logic        Stall,
  output logic        ImemReq,
  output logic [15:0] ImemAddr,
  input  logic [15:0] ImemRdata,
  input  logic        ImemDone,
  output logic        Valid,
  output logic [15:0] Instr,
  output logic [15:0] PC,
  output logic [15:0] IncPC,
  output logic        Halted,
  output logic        Err
);

  typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_HALTED} state_e;

  state_e      state_q, state_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        err_q, err_d;
  logic        squash_q, squash_d;
  logic        launch;
  logic [15:0] launch_pc;
  logic        misaligned;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    req_d      = req_q;
    valid_d    = valid_q;
    halted_d   = halted_q;
    err_d      = err_q;
    squash_d   = squash_q;
    launch     = 1'b0;
    launch_pc  = fetch_pc_q;

    case (state_q)
      ST_ISSUE: begin
        state_d = ST_WAIT;
        if (req_q) begin
          // Request already visible to memory: it must complete, so a redirect squashes it.
          if (Redirect) begin
            squash_d   = 1'b1;
            fetch_pc_d = RedirectPC;
          end
        end else begin
          launch    = 1'b1;
          launch_pc = Redirect ? RedirectPC : fetch_pc_q;
        end
      end
      ST_WAIT: begin
        if (ImemDone) begin
          req_d = 1'b0;
          if (squash_q || Redirect) begin
            state_d  = ST_ISSUE;
            squash_d = 1'b0;
            if (Redirect) fetch_pc_d = RedirectPC;
          end else begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
            instr_d = ImemRdata;
            pc_d    = addr_q;
          end
        end else if (Redirect) begin
          squash_d   = 1'b1;
          fetch_pc_d = RedirectPC;
        end
      end
      ST_HOLD: begin
        if (Redirect) begin
          valid_d   = 1'b0;
          instr_d   = NOP_INSTR;
          state_d   = ST_ISSUE;
          launch    = 1'b1;
          launch_pc = RedirectPC;
        end else if (!Stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (instr_q == 16'h0000) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            launch    = 1'b1;
            launch_pc = pc_q + 16'd2;
          end
        end
      end
      default: ;
    endcase

`ifdef FETCH_ALIGN_CHK_EN
    misaligned = launch_pc[0];
`else
    misaligned = 1'b0;
`endif

    // Every new fetch address funnels through here so the alignment trap sees all of them.
    if (launch) begin
      fetch_pc_d = launch_pc;
      if (misaligned) begin
        state_d  = ST_HALTED;
        req_d    = 1'b0;
        halted_d = 1'b1;
        err_d    = 1'b1;
      end else begin
        req_d  = 1'b1;
        addr_d = launch_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_ISSUE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
      squash_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
      squash_q   <= squash_d;
    end
  end

  assign ImemReq  = req_q;
  assign ImemAddr = addr_q;
  assign Valid    = valid_q;
  assign Instr    = instr_q;
  assign PC       = pc_q;
  assign IncPC    = pc_q + 16'd2;
  assign Halted   = halted_q;
  assign Err      = err_q;

endmodule
